// File: rtl/addsub_arb_pkg.sv
// Shared types and constants for the round-robin add/sub arbiter.
// Optional statistics counters are enabled with ADDSUB_ARB_STATS_EN.
package addsub_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int ADDSUB_WIDTH = 6;

endpackage

// File: rtl/addsub_arbiter_rr_grant.sv
// Round-robin grant: first valid requester at or above rrPtr, wrapping.
// Purely combinational; yields a one-hot grant and its encoded index.
module rr_grant #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grantIdx
);

    logic found;
    int   cand;

    always_comb begin
        grant    = '0;
        grantIdx = '0;
        found    = 1'b0;
        cand     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!found && req_valid[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grantIdx    = ID_W'(cand);
            end
        end
    end

endmodule

// File: rtl/addsub_arbiter.sv
// Shares one add/sub datapath between NUM_REQ requesters, round-robin.
// Define ADDSUB_ARB_STATS_EN to add saturating op/overflow counters.
module addsub_arbiter
    import addsub_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int WIDTH   = ADDSUB_WIDTH,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ-1:0]       req_addsub,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [ID_W-1:0]          resp_id,
    output logic [WIDTH-1:0]         resp_z,
    output logic                     resp_overflow
`ifdef ADDSUB_ARB_STATS_EN
    ,
    output logic [15:0]              op_count,
    output logic [15:0]              ovf_count
`endif
);

    arb_state_t state, nextState;

    logic [ID_W-1:0]    rrPtr;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grantIdx;
    logic [WIDTH-1:0]   latA, latB;
    logic               latOp;
    logic [ID_W-1:0]    latId;
    logic               accept, respFire;
    logic [WIDTH-1:0]   bEff, sumZ;
    logic               sumOvf;

    rr_grant #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) uGrant (
        .req_valid (req_valid),
        .rr_ptr    (rrPtr),
        .grant     (grant),
        .grantIdx  (grantIdx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        req_ready = '0;
        accept    = 1'b0;
        respFire  = 1'b0;
        unique case (state)
            IDLE: begin
                if (!reset) begin
                    req_ready = grant;
                end
                accept = |(req_valid & req_ready);
                if (accept) begin
                    nextState = EXEC;
                end
            end
            EXEC: nextState = RESP;
            RESP: begin
                respFire = resp_ready;
                if (respFire) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    assign resp_valid = (state == RESP);

    // Subtract is a + ~b + 1; overflow checked on sign bits of a, b, z.
    always_comb begin
        bEff = (latOp == OP_SUB) ? ~latB : latB;
        sumZ = latA + bEff + {{(WIDTH-1){1'b0}}, latOp};
        if (latOp == OP_SUB) begin
            sumOvf = (latA[WIDTH-1] != latB[WIDTH-1]) &&
                     (sumZ[WIDTH-1] != latA[WIDTH-1]);
        end else begin
            sumOvf = (latA[WIDTH-1] == latB[WIDTH-1]) &&
                     (sumZ[WIDTH-1] != latA[WIDTH-1]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rrPtr         <= '0;
            latA          <= '0;
            latB          <= '0;
            latOp         <= 1'b0;
            latId         <= '0;
            resp_id       <= '0;
            resp_z        <= '0;
            resp_overflow <= 1'b0;
        end else begin
            if (accept) begin
                latA  <= req_a[grantIdx*WIDTH +: WIDTH];
                latB  <= req_b[grantIdx*WIDTH +: WIDTH];
                latOp <= req_addsub[grantIdx];
                latId <= grantIdx;
            end
            if (state == EXEC) begin
                resp_z        <= sumZ;
                resp_overflow <= sumOvf;
                resp_id       <= latId;
            end
            // Pointer moves only once the result has been taken.
            if (respFire) begin
                if (latId == ID_W'(NUM_REQ - 1)) begin
                    rrPtr <= '0;
                end else begin
                    rrPtr <= latId + 1'b1;
                end
            end
        end
    end

`ifdef ADDSUB_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            op_count  <= '0;
            ovf_count <= '0;
        end else if (respFire) begin
            if (op_count != 16'hFFFF) begin
                op_count <= op_count + 16'd1;
            end
            if (resp_overflow && ovf_count != 16'hFFFF) begin
                ovf_count <= ovf_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_addsub_arbiter.sv
// Scoreboard bench for addsub_arbiter: directed cases then random traffic.
// Reference model uses signed integer arithmetic and a simple grant search.
module tb_addsub_arbiter;

    localparam int N  = 2;
    localparam int W  = 6;
    localparam int IW = 1;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   req_addsub = '0;
    logic [N*W-1:0] req_a = '0;
    logic [N*W-1:0] req_b = '0;
    logic           resp_valid;
    logic           resp_ready = 1'b1;
    logic [IW-1:0]  resp_id;
    logic [W-1:0]   resp_z;
    logic           resp_overflow;
`ifdef ADDSUB_ARB_STATS_EN
    logic [15:0]    op_count;
    logic [15:0]    ovf_count;
`endif

    addsub_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addsub    (req_addsub),
        .req_a         (req_a),
        .req_b         (req_b),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_id       (resp_id),
        .resp_z        (resp_z),
        .resp_overflow (resp_overflow)
`ifdef ADDSUB_ARB_STATS_EN
        ,
        .op_count      (op_count),
        .ovf_count     (ovf_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] z;
        bit           ovf;
        int           id;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   ptr = 0;
    bit   busy = 1'b0;
    int   age = 0;
    int   opCnt = 0;
    int   ovfCnt = 0;

    task automatic check(input bit ok, input string name,
                         input int act, input int req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t",
                     name, act, req, $time);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a,
                                   input logic [W-1:0] b,
                                   input bit op, input int id);
        exp_t e;
        int sa, sb, r;
        sa = $signed(a);
        sb = $signed(b);
        r = op ? (sa - sb) : (sa + sb);
        e.z = W'(r);
        e.ovf = (r > 31) || (r < -32);
        e.id = id;
        return e;
    endfunction

    // Monitor / scoreboard: runs on the falling edge, away from updates.
    always @(negedge clk) begin
        logic [N-1:0] expReady;
        bit expValid, found;
        int idx;
        exp_t e;
        if (reset) begin
            check(req_ready == '0, "rst_ready", int'(req_ready), 0);
            q.delete();
            busy = 1'b0;
            ptr = 0;
            age = 0;
            opCnt = 0;
            ovfCnt = 0;
        end else begin
`ifdef ADDSUB_ARB_STATS_EN
            check(op_count == 16'(opCnt), "op_count", int'(op_count), opCnt);
            check(ovf_count == 16'(ovfCnt), "ovf_count",
                  int'(ovf_count), ovfCnt);
`endif
            expReady = '0;
            found = 1'b0;
            if (!busy) begin
                for (int k = 0; k < N; k++) begin
                    idx = (ptr + k) % N;
                    if (!found && req_valid[idx]) begin
                        found = 1'b1;
                        expReady[idx] = 1'b1;
                    end
                end
            end
            check(req_ready == expReady, "req_ready",
                  int'(req_ready), int'(expReady));
            expValid = busy && (age >= 2);
            check(resp_valid == expValid, "resp_valid",
                  int'(resp_valid), int'(expValid));
            if (resp_valid && expValid && q.size() > 0) begin
                check(resp_z == q[0].z, "resp_z", int'(resp_z), int'(q[0].z));
                check(resp_overflow == q[0].ovf, "resp_overflow",
                      int'(resp_overflow), int'(q[0].ovf));
                check(int'(resp_id) == q[0].id, "resp_id",
                      int'(resp_id), q[0].id);
            end
            if (expValid && resp_ready && q.size() > 0) begin
                e = q.pop_front();
                ptr = (e.id + 1) % N;
                busy = 1'b0;
                if (opCnt < 65535) opCnt++;
                if (e.ovf && ovfCnt < 65535) ovfCnt++;
            end else if (busy) begin
                age++;
            end
            if (|(req_valid & expReady)) begin
                for (int i = 0; i < N; i++) begin
                    if (expReady[i]) begin
                        q.push_back(model(req_a[i*W +: W], req_b[i*W +: W],
                                          req_addsub[i], i));
                    end
                end
                busy = 1'b1;
                age = 1;
            end
        end
    end

    task automatic setReq(input int i, input logic [W-1:0] a,
                          input logic [W-1:0] b, input bit op);
        req_valid[i] = 1'b1;
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_addsub[i] = op;
    endtask

    // Present one request and return just after the accepting edge.
    task automatic issue(input int i, input logic [W-1:0] a,
                         input logic [W-1:0] b, input bit op);
        bit got;
        got = 1'b0;
        req_valid = '0;
        setReq(i, a, b, op);
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            got = req_ready[i];
        end
        check(got, "accept_timeout", int'(got), 1);
        @(posedge clk);
        #1;
        req_valid = '0;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset = 1'b1;
        cycles(3);
        reset = 1'b0;
        @(negedge clk);
        check(resp_valid == 1'b0, "rst_resp_valid", int'(resp_valid), 0);
        check(resp_z == '0, "rst_resp_z", int'(resp_z), 0);
        check(resp_id == '0, "rst_resp_id", int'(resp_id), 0);
        check(resp_overflow == 1'b0, "rst_resp_ovf", int'(resp_overflow), 0);
        @(posedge clk);
        #1;

        resp_ready = 1'b1;
        issue(0, 6'd10, 6'd3, 1'b1);
        cycles(3);
        issue(1, 6'd31, 6'd1, 1'b0);
        cycles(3);
        issue(0, 6'b100000, 6'd1, 1'b1);
        cycles(3);

        setReq(0, 6'd5, 6'd7, 1'b0);
        setReq(1, 6'd20, 6'd25, 1'b1);
        cycles(13);
        req_valid = '0;
        cycles(3);

        resp_ready = 1'b0;
        issue(1, 6'd17, 6'd17, 1'b0);
        cycles(7);
        resp_ready = 1'b1;
        cycles(3);

        issue(0, 6'd30, 6'd30, 1'b0);
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        @(negedge clk);
        check(resp_valid == 1'b0, "post_rst_valid", int'(resp_valid), 0);
`ifdef ADDSUB_ARB_STATS_EN
        check(op_count == 16'd0, "post_rst_op_count", int'(op_count), 0);
        check(ovf_count == 16'd0, "post_rst_ovf_count", int'(ovf_count), 0);
`endif
        @(posedge clk);
        #1;
        issue(1, 6'd1, 6'd2, 1'b0);
        cycles(3);

        for (int c = 0; c < 1500; c++) begin
            reset = ($urandom_range(0, 299) == 0);
            req_valid = N'($urandom);
            req_addsub = N'($urandom);
            for (int i = 0; i < N; i++) begin
                req_a[i*W +: W] = W'($urandom);
                req_b[i*W +: W] = W'($urandom);
            end
            resp_ready = ($urandom_range(0, 3) != 0);
            cycles(1);
        end

        reset = 1'b0;
        req_valid = '0;
        resp_ready = 1'b1;
        cycles(6);
        @(negedge clk);
        check(q.size() == 0, "drain_queue", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/addsub_arbiter.md
Name: addsub_arbiter

Overview:
- Shares one 6-bit add/subtract datapath between NUM_REQ requesters.
- Uses round-robin arbitration with valid/ready handshakes on both the request and response sides.
- Sits between the operand sources (switch banks or sequencers) and the display/result logic.
- Tags each result with the requester ID and an overflow flag, and holds it until the consumer accepts it.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- WIDTH, 6, operand and result width in bits (two's complement).
- ID_W, $clog2(NUM_REQ) (minimum 1), requester ID width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_addsub  in  NUM_REQ  per-requester opcode: 0 = a+b, 1 = a-b.
- req_a  in  NUM_REQ*WIDTH  packed operand A; requester i uses bits [i*WIDTH +: WIDTH].
- req_b  in  NUM_REQ*WIDTH  packed operand B; same packing as req_a.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts the result.
- resp_id  out  ID_W  index of the requester that owns the result.
- resp_z  out  WIDTH  sum or difference.
- resp_overflow  out  1  signed overflow of the operation.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high. reset is sampled only on a rising edge of clk.
- FSM states: IDLE, EXEC, RESP. Reset puts the FSM in IDLE.
- Reset values:
  - rr_ptr = 0.
  - resp_valid = 0, resp_id = 0, resp_z = 0, resp_overflow = 0.
  - Latched operand/op/id registers = 0.
  - req_ready = 0 in the reset cycle.
- Grant rule:
  - Grant goes to the first i with req_valid[i]=1, searching from rr_ptr upward and wrapping modulo NUM_REQ.
  - req_ready[grant] = 1 only in IDLE and only when at least one request is valid. Otherwise req_ready = 0.
  - req_ready is combinational from req_valid and rr_ptr.
- IDLE:
  - On an accept (req_valid[i] & req_ready[i]), latch a, b, addsub and id = i, then go to EXEC.
  - With no valid request, stay in IDLE.
- EXEC (1 cycle):
  - Compute z = a + b, or a + ~b + 1 for subtract, truncated to WIDTH.
  - Add overflow = (a[MSB] == b[MSB]) & (z[MSB] != a[MSB]).
  - Subtract overflow = (a[MSB] != b[MSB]) & (z[MSB] != a[MSB]).
  - Register z, overflow and id into the resp_* outputs, then go to RESP.
- RESP:
  - resp_valid = 1. resp_z, resp_overflow and resp_id stay stable until the handshake.
  - On resp_valid & resp_ready: rr_ptr = (id + 1) mod NUM_REQ, resp_valid deasserts on the next edge, go to IDLE.
  - resp_ready held low stalls indefinitely; no new request is accepted while stalled.
- Latency and throughput:
  - Accept in cycle T gives resp_valid high from cycle T+2.
  - Best-case throughput is one operation per 3 cycles.
- Fairness:
  - A continuously requesting input is served within NUM_REQ grants.
  - rr_ptr advances only on a completed response, never on the accept.
- Boundary cases:
  - Requester that drops req_valid before the grant: nothing is latched and no error is raised.
  - rr_ptr wrap: after serving NUM_REQ-1, rr_ptr becomes 0.
  - reset asserted in EXEC or RESP: the in-flight operation is discarded, all reset values apply, no response is emitted.
  - Operand widths: operands are WIDTH bits, there is no carry-out port, and results wrap modulo 2^WIDTH.

Optional Feature:
- Macro: ADDSUB_ARB_STATS_EN.
- When defined:
  - Adds ports op_count out 16 and ovf_count out 16.
  - op_count increments on each response handshake.
  - ovf_count increments on each response handshake where resp_overflow = 1.
  - Both counters saturate at 16'hFFFF and clear on reset.
- When undefined: the ports and counters are absent, and all other behaviour is unchanged.

Decomposition:
- Package addsub_arb_pkg holds:
  - Enum arb_state_t {IDLE, EXEC, RESP}.
  - Localparams OP_ADD = 1'b0 and OP_SUB = 1'b1.
  - Default WIDTH constant.
- Sub-module rr_grant (combinational): inputs req_valid and rr_ptr; outputs a one-hot grant and its encoded index.
- The add/sub computation stays inline in the EXEC datapath. It matches the team's existing 6-bit add/sub overflow rules.

Test Plan:
- Reset, then requester 0: a=10, b=3, addsub=1 → accepted in cycle T; resp_valid at T+2 with z=7, overflow=0, id=0.
- Requester 1: a=31, b=1, addsub=0 → z=6'b100000 (-32), overflow=1, id=1.
- Requester 0: a=-32 (6'b100000), b=1, addsub=1 → z=31, overflow=1.
- Both requesters valid continuously with resp_ready=1 → grant order 0,1,0,1; each response 3 cycles apart.
- resp_ready held low for 5 cycles in RESP → resp_* stable; req_ready stays 0; response completes on the first cycle resp_ready=1.
- reset pulsed for 1 cycle while in EXEC → next cycle is IDLE with resp_valid=0 and rr_ptr=0, and no response is emitted. With ADDSUB_ARB_STATS_EN defined, the counters read 0 after the reset.
